// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared owner encoding, default widths and read-tag layout
package sram_port_arbiter_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DMA = 1'b1;
  typedef struct packed {
    logic valid;
    logic owner;
  } tag_t;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: one requester port (request, command fields, grant, read return)
interface sram_port_arbiter_if
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  modport master(output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave(input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_port_arbiter_tag_delay.sv
// sram_port_arbiter_tag_delay: fixed-length delay line carrying read tags alongside SRAM latency
module sram_port_arbiter_tag_delay #(
  parameter int DELAY = 2,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] pipe [DELAY];
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      for (int i = 0; i < DELAY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DELAY; i++) pipe[i] <= pipe[i-1];
    end
  assign q = pipe[DELAY-1];
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one single-port SRAM between CPU and DMA ports with registered commands
// and in-order read return; round-robin or CPU priority with bounded DMA starvation.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              cpu_prio,
  sram_port_arbiter_if.slave cpu,
  sram_port_arbiter_if.slave dma,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_write_en,
  output logic [DATA_W-1:0] sram_data_out,
  input  logic [DATA_W-1:0] sram_data_in
);
  localparam int WC_W = $clog2(MAX_WAIT + 1);
  logic [WC_W-1:0] wait_cnt;
  logic            rr_last;
  logic            dma_win;
  logic            accept;
  logic            sel;
  logic            sel_we;
  tag_t            tag_in;
  tag_t            tag_out;
  always_comb begin
    dma_win    = cpu_prio ? (wait_cnt == WC_W'(MAX_WAIT)) : (rr_last == OWNER_CPU);
    cpu.gnt    = !arst && cpu.req && !(dma.req && dma_win);
    dma.gnt    = !arst && dma.req && (!cpu.req || dma_win);
    accept     = cpu.gnt || dma.gnt;
    sel        = dma.gnt ? OWNER_DMA : OWNER_CPU;
    sel_we     = sel ? dma.we : cpu.we;
    tag_in.valid = accept && !sel_we;
    tag_in.owner = sel;
  end
  sram_port_arbiter_tag_delay #(
    .DELAY(RD_LAT + 1),
    .WIDTH($bits(tag_t))
  ) u_tag (
    .clk (clk),
    .arst(arst),
    .d   (tag_in),
    .q   (tag_out)
  );
  // wait_cnt tracks DMA denial in both modes so a mode switch keeps its history
  always_ff @(posedge clk or posedge arst)
    if (arst) begin
      wait_cnt      <= '0;
      rr_last       <= OWNER_DMA;
      sram_addr     <= '0;
      sram_write_en <= 1'b0;
      sram_data_out <= '0;
      cpu.rvalid    <= 1'b0;
      cpu.rdata     <= '0;
      dma.rvalid    <= 1'b0;
      dma.rdata     <= '0;
    end else begin
      wait_cnt <= (!dma.req || dma.gnt) ? '0 : (wait_cnt == WC_W'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
      if (accept) begin
        rr_last       <= sel;
        sram_addr     <= sel ? dma.addr : cpu.addr;
        sram_data_out <= sel ? dma.wdata : cpu.wdata;
      end
      sram_write_en <= accept && sel_we;
      cpu.rvalid    <= tag_out.valid && tag_out.owner == OWNER_CPU;
      dma.rvalid    <= tag_out.valid && tag_out.owner == OWNER_DMA;
      if (tag_out.valid && tag_out.owner == OWNER_CPU) cpu.rdata <= sram_data_in;
      if (tag_out.valid && tag_out.owner == OWNER_DMA) dma.rdata <= sram_data_in;
    end
endmodule
